// File: rtl/ex_mem_preg.sv
// rtl/ex_mem_preg.sv - EX/MEM pipeline register with valid, stall/flush and MEM-stage forwarding match
// Optional EXMEM_PERF_CNT_EN adds saturating stall_cnt/bubble_cnt counters.
module ex_mem_preg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MEMWR_W = 2,
  parameter int MEMRD_W = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic               ex_Zero,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic [DATA_W-1:0]  ex_busB,
  input  logic [REG_AW-1:0]  ex_Rw,
  input  logic               ex_RegWr,
  input  logic [MEMWR_W-1:0] ex_MemWr,
  input  logic               ex_MemtoReg,
  input  logic [MEMRD_W-1:0] ex_MemRead,
  input  logic [REG_AW-1:0]  ex_Rs,
  input  logic [REG_AW-1:0]  ex_Rt,
  output logic               mem_valid,
  output logic               mem_Zero,
  output logic [DATA_W-1:0]  mem_alu_result,
  output logic [DATA_W-1:0]  mem_busB,
  output logic [REG_AW-1:0]  mem_Rw,
  output logic               mem_RegWr,
  output logic [MEMWR_W-1:0] mem_MemWr,
  output logic               mem_MemtoReg,
  output logic [MEMRD_W-1:0] mem_MemRead,
  output logic               fwd_a_mem,
  output logic               fwd_b_mem,
  output logic               mem_is_load
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  logic               r_valid;
  logic               r_zero;
  logic [DATA_W-1:0]  r_alu_result;
  logic [DATA_W-1:0]  r_bus_b;
  logic [REG_AW-1:0]  r_rw;
  logic               r_reg_wr;
  logic [MEMWR_W-1:0] r_mem_wr;
  logic               r_mem_to_reg;
  logic [MEMRD_W-1:0] r_mem_read;

  logic w_is_load;
  logic w_fwd_src;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid      <= 1'b0;
      r_zero       <= 1'b0;
      r_alu_result <= '0;
      r_bus_b      <= '0;
      r_rw         <= '0;
      r_reg_wr     <= 1'b0;
      r_mem_wr     <= '0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= '0;
    end else if (flush) begin
      // Flush kills control only; data and Rw keep their old values.
      r_valid      <= 1'b0;
      r_zero       <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_mem_wr     <= '0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= '0;
    end else if (!stall) begin
      r_alu_result <= ex_alu_result;
      r_bus_b      <= ex_busB;
      r_rw         <= ex_Rw;
      r_valid      <= ex_valid;
      r_zero       <= ex_valid & ex_Zero;
      r_reg_wr     <= ex_valid & ex_RegWr;
      r_mem_wr     <= ex_valid ? ex_MemWr : '0;
      r_mem_to_reg <= ex_valid & ex_MemtoReg;
      r_mem_read   <= ex_valid ? ex_MemRead : '0;
    end
  end

  assign w_is_load = r_valid & (r_mem_read != '0);
  // A load in MEM has no data yet, so it never forwards; the hazard unit stalls instead.
  assign w_fwd_src = r_valid & r_reg_wr & (r_rw != '0) & ~w_is_load;

  assign fwd_a_mem = w_fwd_src & (r_rw == ex_Rs);
  assign fwd_b_mem = w_fwd_src & (r_rw == ex_Rt);

  assign mem_valid      = r_valid;
  assign mem_Zero       = r_zero;
  assign mem_alu_result = r_alu_result;
  assign mem_busB       = r_bus_b;
  assign mem_Rw         = r_rw;
  assign mem_RegWr      = r_reg_wr;
  assign mem_MemWr      = r_mem_wr;
  assign mem_MemtoReg   = r_mem_to_reg;
  assign mem_MemRead    = r_mem_read;
  assign mem_is_load    = w_is_load;

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  logic        w_stall_evt;
  logic        w_bubble_evt;

  assign w_stall_evt  = stall & ~flush;
  assign w_bubble_evt = flush | (~ex_valid & ~stall);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_bubble_evt && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_preg.sv
// tb/tb_ex_mem_preg.sv - directed table-driven bench for ex_mem_preg
module tb_ex_mem_preg;

  localparam logic [31:0] MASK = 32'h5A5A_0000;

  logic        Clk;
  logic        Rst_n;
  logic        stall, flush, ex_valid, ex_Zero;
  logic [31:0] ex_alu_result, ex_busB;
  logic [4:0]  ex_Rw, ex_Rs, ex_Rt;
  logic        ex_RegWr, ex_MemtoReg;
  logic [1:0]  ex_MemWr, ex_MemRead;
  logic        mem_valid, mem_Zero, mem_RegWr, mem_MemtoReg;
  logic [31:0] mem_alu_result, mem_busB;
  logic [4:0]  mem_Rw;
  logic [1:0]  mem_MemWr, mem_MemRead;
  logic        fwd_a_mem, fwd_b_mem, mem_is_load;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  ex_mem_preg dut (
    .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_Zero(ex_Zero), .ex_alu_result(ex_alu_result), .ex_busB(ex_busB), .ex_Rw(ex_Rw),
    .ex_RegWr(ex_RegWr), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg),
    .ex_MemRead(ex_MemRead), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt),
    .mem_valid(mem_valid), .mem_Zero(mem_Zero), .mem_alu_result(mem_alu_result),
    .mem_busB(mem_busB), .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr), .mem_MemWr(mem_MemWr),
    .mem_MemtoReg(mem_MemtoReg), .mem_MemRead(mem_MemRead),
    .fwd_a_mem(fwd_a_mem), .fwd_b_mem(fwd_b_mem), .mem_is_load(mem_is_load)
`ifdef EXMEM_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        st, fl, v;
    logic [31:0] alu;
    logic [4:0]  rw;
    logic        regwr;
    logic [1:0]  memwr, memrd;
    logic [4:0]  rs, rt;
    logic        e_valid;
    logic [31:0] e_alu;
    logic [4:0]  e_rw;
    logic        e_regwr;
    logic [1:0]  e_memwr, e_memrd;
    logic        e_load, e_fa, e_fb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    stall         = x.st;
    flush         = x.fl;
    ex_valid      = x.v;
    ex_alu_result = x.alu;
    ex_busB       = x.alu ^ MASK;
    ex_Zero       = (x.alu == 32'd0);
    ex_Rw         = x.rw;
    ex_RegWr      = x.regwr;
    ex_MemWr      = x.memwr;
    ex_MemRead    = x.memrd;
    ex_MemtoReg   = (x.memrd != 2'd0);
    ex_Rs         = x.rs;
    ex_Rt         = x.rt;
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 32'(mem_valid), 32'd0);
    chk({tag, " alu"}, mem_alu_result, 32'd0);
    chk({tag, " busB"}, mem_busB, 32'd0);
    chk({tag, " rw"}, 32'(mem_Rw), 32'd0);
    chk({tag, " ctrl"}, {26'd0, mem_RegWr, mem_MemWr, mem_MemRead, mem_MemtoReg}, 32'd0);
  endtask

  initial begin
    // st fl v  alu  rw regwr memwr memrd rs rt | valid alu rw regwr memwr memrd load fa fb
    vecs[0]  = '{1'b0,1'b0,1'b1,32'hDEADBEEF,5'd5,1'b1,2'd0,2'd0,5'd5,5'd0,
                 1'b1,32'hDEADBEEF,5'd5,1'b1,2'd0,2'd0,1'b0,1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,32'hA5A5A5A5,5'd7,1'b1,2'd0,2'd0,5'd7,5'd3,
                 1'b1,32'hA5A5A5A5,5'd7,1'b1,2'd0,2'd0,1'b0,1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b1,32'h11111111,5'd2,1'b0,2'd1,2'd0,5'd7,5'd7,
                 1'b1,32'hA5A5A5A5,5'd7,1'b1,2'd0,2'd0,1'b0,1'b1,1'b1};
    vecs[3]  = '{1'b1,1'b0,1'b0,32'h22222222,5'd3,1'b1,2'd0,2'd2,5'd1,5'd7,
                 1'b1,32'hA5A5A5A5,5'd7,1'b1,2'd0,2'd0,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b1,32'h33333333,5'd4,1'b1,2'd3,2'd0,5'd0,5'd0,
                 1'b1,32'hA5A5A5A5,5'd7,1'b1,2'd0,2'd0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b1,32'h00000100,5'd4,1'b0,2'd3,2'd0,5'd4,5'd4,
                 1'b1,32'h00000100,5'd4,1'b0,2'd3,2'd0,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b1,1'b1,32'h55555555,5'd9,1'b1,2'd1,2'd0,5'd4,5'd9,
                 1'b0,32'h00000100,5'd4,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,32'h00000000,5'd0,1'b1,2'd0,2'd0,5'd0,5'd0,
                 1'b1,32'h00000000,5'd0,1'b1,2'd0,2'd0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b1,32'h00000200,5'd9,1'b1,2'd0,2'd1,5'd0,5'd9,
                 1'b1,32'h00000200,5'd9,1'b1,2'd0,2'd1,1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h00000300,5'd6,1'b1,2'd2,2'd2,5'd6,5'd6,
                 1'b0,32'h00000300,5'd6,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1,32'h00000400,5'd9,1'b1,2'd0,2'd0,5'd1,5'd9,
                 1'b1,32'h00000400,5'd9,1'b1,2'd0,2'd0,1'b0,1'b0,1'b1};

    Rst_n = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge Clk);
    chk_zero("reset");
    chk("reset fwd_a", 32'(fwd_a_mem), 32'd0);
`ifdef EXMEM_PERF_CNT_EN
    chk("reset stall_cnt", stall_cnt, 32'd0);
    chk("reset bubble_cnt", bubble_cnt, 32'd0);
`endif
    Rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d valid", i), 32'(mem_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d alu", i), mem_alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d busB", i), mem_busB, vecs[i].e_alu ^ MASK);
      chk($sformatf("v%0d rw", i), 32'(mem_Rw), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d regwr", i), 32'(mem_RegWr), 32'(vecs[i].e_regwr));
      chk($sformatf("v%0d memwr", i), 32'(mem_MemWr), 32'(vecs[i].e_memwr));
      chk($sformatf("v%0d memrd", i), 32'(mem_MemRead), 32'(vecs[i].e_memrd));
      chk($sformatf("v%0d memtoreg", i), 32'(mem_MemtoReg),
          32'(vecs[i].e_valid && (vecs[i].e_memrd != 2'd0)));
      chk($sformatf("v%0d zero", i), 32'(mem_Zero),
          32'(vecs[i].e_valid && (vecs[i].e_alu == 32'd0)));
      chk($sformatf("v%0d is_load", i), 32'(mem_is_load), 32'(vecs[i].e_load));
      chk($sformatf("v%0d fwd_a", i), 32'(fwd_a_mem), 32'(vecs[i].e_fa));
      chk($sformatf("v%0d fwd_b", i), 32'(fwd_b_mem), 32'(vecs[i].e_fb));
    end

    // Asynchronous reset mid-cycle while stalling with a full stage
    drive('{1'b0,1'b0,1'b1,32'h00001234,5'd3,1'b1,2'd1,2'd1,5'd0,5'd0,
            1'b0,32'd0,5'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0});
    step();
    chk("pre-reset alu", mem_alu_result, 32'h00001234);
    stall = 1'b1;
    #2 Rst_n = 1'b0;
    #1 chk_zero("async reset");
    @(negedge Clk);
    chk_zero("reset held");
    Rst_n = 1'b1;
    drive('{1'b0,1'b0,1'b1,32'hDEADBEEF,5'd5,1'b1,2'd0,2'd0,5'd0,5'd0,
            1'b0,32'd0,5'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0});
    step();
    chk("post-reset alu", mem_alu_result, 32'hDEADBEEF);
    chk("post-reset rw", 32'(mem_Rw), 32'd5);
    chk("post-reset valid", 32'(mem_valid), 32'd1);

`ifdef EXMEM_PERF_CNT_EN
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    stall = 1'b1; flush = 1'b0; ex_valid = 1'b1;
    repeat (4) step();
    stall = 1'b0; flush = 1'b1;
    repeat (2) step();
    flush = 1'b0; ex_valid = 1'b0;
    step();
    ex_valid = 1'b1;
    chk("perf stall_cnt", stall_cnt, 32'd4);
    chk("perf bubble_cnt", bubble_cnt, 32'd3);
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_stall_cnt;
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("perf stall_cnt sat", stall_cnt, 32'hFFFF_FFFF);
    chk("perf bubble_cnt hold", bubble_cnt, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_preg.md
Name: ex_mem_preg

Overview:
- Parametrised EX/MEM pipeline register for the 5-stage pipeline. Sits between the ALU stage and the data-memory stage.
- Adds the following over a plain flop stage:
  - valid bit, stall (hold) and flush (bubble) control;
  - asynchronous active-low reset;
  - registered-state forwarding-match outputs that tell the EX-stage operand muxes when to bypass from MEM.

Parameters:
DATA_W, 32, width of alu_result and busB
REG_AW, 5, register-file address width (Rw, Rs, Rt)
MEMWR_W, 2, width of MemWr byte/half/word write-control code
MEMRD_W, 2, width of MemRead load-type code

Ports:
Clk  input  1  pipeline clock, rising edge
Rst_n  input  1  asynchronous reset, active low
stall  input  1  hold all stage contents this cycle
flush  input  1  load a bubble this cycle; overrides stall
ex_valid  input  1  EX stage holds a real instruction
ex_Zero  input  1  ALU zero flag
ex_alu_result  input  DATA_W  ALU result / memory address
ex_busB  input  DATA_W  store data
ex_Rw  input  REG_AW  destination register
ex_RegWr  input  1  register write enable
ex_MemWr  input  MEMWR_W  data-memory write code, 0 = no write
ex_MemtoReg  input  1  writeback mux select
ex_MemRead  input  MEMRD_W  load type, 0 = no read
ex_Rs  input  REG_AW  source A of the instruction currently in EX
ex_Rt  input  REG_AW  source B of the instruction currently in EX
mem_valid  output  1  MEM stage holds a real instruction
mem_Zero, mem_alu_result, mem_busB, mem_Rw, mem_RegWr, mem_MemWr, mem_MemtoReg, mem_MemRead  output  widths as the ex_ counterparts  registered stage contents
fwd_a_mem  output  1  EX source A must bypass from mem_alu_result
fwd_b_mem  output  1  EX source B must bypass from mem_alu_result
mem_is_load  output  1  mem_valid and mem_MemRead != 0

Behaviour:
- Reset: Rst_n low forces every registered output to 0 immediately, with no clock needed. Release is synchronous to the next Clk edge.
- Latency: 1 cycle. Inputs sampled on a rising edge appear on the mem_ outputs after that edge.
- Priority per edge: flush > stall > ex_valid=0 bubble > normal load.
- flush=1:
  - mem_valid, mem_Zero, mem_RegWr, mem_MemWr, mem_MemtoReg and mem_MemRead all go to 0;
  - mem_alu_result, mem_busB and mem_Rw hold their previous values.
- stall=1 with flush=0: every register holds, including data and valid.
- ex_valid=0 with no stall or flush:
  - same as flush for the control fields and valid;
  - data fields load the inputs (don't-care values, but deterministic).
- Normal load: all fields copy their ex_ counterpart; mem_valid goes to 1.
- Invariant: mem_valid=0 implies mem_RegWr=0, mem_MemWr=0 and mem_MemRead=0. The MEM stage never writes memory or the register file from a bubble.
- Forwarding (combinational from registered state plus ex_Rs/ex_Rt):
  - fwd_a_mem = mem_valid & mem_RegWr & (mem_Rw != 0) & (mem_Rw == ex_Rs);
  - fwd_b_mem uses the same expression with ex_Rt;
  - both drop to 0 while mem_is_load is 1, because load data is not yet available; the hazard unit stalls instead.
- Register 0 never forwards.
- Stall and flush asserted together on the same edge: flush wins.
- Reset asserted mid-stall: state goes to 0 and the stall is irrelevant.

Optional Feature:
- Macro EXMEM_PERF_CNT_EN.
- When defined:
  - adds outputs stall_cnt [31:0] and bubble_cnt [31:0], both reset to 0 by Rst_n;
  - stall_cnt increments on each edge with stall=1 and flush=0;
  - bubble_cnt increments on each edge that loads a bubble (flush=1, or ex_valid=0 with no stall);
  - both counters saturate at 32'hFFFFFFFF.
- When undefined: these ports and their logic do not exist, and all other behaviour is identical.

Test Plan:
- Reset: drive Rst_n low mid-cycle with stage full (alu_result=32'h1234) -> all outputs 0 before the next edge; after release plus one edge with ex_valid=1, ex_alu_result=32'hDEAD_BEEF, ex_Rw=5, ex_RegWr=1 -> mem_alu_result=32'hDEADBEEF, mem_Rw=5, mem_valid=1.
- Stall hold: load alu_result=32'hA5A5A5A5, then stall=1 for 3 edges while ex_alu_result changes -> mem_alu_result stays 32'hA5A5A5A5 and mem_valid stays 1 throughout.
- Flush over stall: stage holds a store (mem_MemWr=2'b11), then stall=1 and flush=1 together -> after the edge mem_MemWr=0, mem_RegWr=0, mem_valid=0, and mem_Rw is unchanged.
- Forwarding: mem_Rw=7, mem_RegWr=1, mem_MemRead=0; set ex_Rs=7, ex_Rt=3 -> fwd_a_mem=1, fwd_b_mem=0. Set mem_Rw=0 with ex_Rs=0 -> fwd_a_mem=0.
- Load suppression: mem_MemRead=2'b01, mem_RegWr=1, mem_Rw=9, ex_Rt=9 -> mem_is_load=1 and fwd_b_mem=0.
- With EXMEM_PERF_CNT_EN defined: 4 stall edges, 2 flush edges and 1 ex_valid=0 edge -> stall_cnt=4, bubble_cnt=3. Preload the counter to 32'hFFFFFFFF via force, then one more stall -> stall_cnt stays 32'hFFFFFFFF.
